// File: rtl/i2c_xfer_sequencer.sv
// i2c_xfer_sequencer
//   Sequences one I2C transfer (address byte, N data bytes, STOP or retained
//   bus for a repeated start). It drives a byte-level I2C controller and
//   paces the TX/RX FIFOs.
//
// Optional feature: define I2C_SEQ_WDOG_EN to add a watchdog. The watchdog
//   aborts the transfer to DONE with timeout_err set if ADDR, DATA or STOP
//   sees no progress for WDOG_CYCLES cycles.
//
// Ports
//   core_clk, rst_n                 clock, async active-low reset
//   start, abort, rw, slave_addr,
//   byte_count, rep_start           transfer request from the host side
//   addr_done, byte_done, ack_n,
//   bus_idle                        progress events from the I2C controller
//   tx_empty, rx_full               FIFO status
//   i2c_enable, i2c_rw, i2c_addr,
//   repeated_start_cond, i2c_hold   controller commands
//   fifo_tx_enable, fifo_rx_enable  one-cycle FIFO pop/push strobes
//   busy, done, nack_err,
//   timeout_err, remaining          status
module i2c_xfer_sequencer #(
  parameter int CNT_W       = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic             core_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             rw,
  input  logic [6:0]       slave_addr,
  input  logic [CNT_W-1:0] byte_count,
  input  logic             rep_start,
  input  logic             addr_done,
  input  logic             byte_done,
  input  logic             ack_n,
  input  logic             bus_idle,
  input  logic             tx_empty,
  input  logic             rx_full,
  output logic             i2c_enable,
  output logic             i2c_rw,
  output logic [6:0]       i2c_addr,
  output logic             repeated_start_cond,
  output logic             i2c_hold,
  output logic             fifo_tx_enable,
  output logic             fifo_rx_enable,
  output logic             busy,
  output logic             done,
  output logic             nack_err,
  output logic             timeout_err,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_STALL, S_STOP, S_HOLD, S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_rw, r_rep, r_nack, r_rsc, r_tx_pend;
  logic [6:0]       r_addr;
  logic [CNT_W-1:0] r_rem;

  logic             w_latch, w_rsc_set, w_dec, w_nack_set;
  logic             w_enter_data, w_rx_pulse, w_wdog_fire;
  logic [CNT_W-1:0] w_rem_dec;

  // Saturating decrement: remaining never wraps below zero.
  assign w_rem_dec = (r_rem != '0) ? r_rem - 1'b1 : '0;

  always_comb begin
    w_state_nxt  = r_state;
    w_latch      = 1'b0;
    w_rsc_set    = 1'b0;
    w_dec        = 1'b0;
    w_nack_set   = 1'b0;
    w_enter_data = 1'b0;
    w_rx_pulse   = 1'b0;
    if (w_wdog_fire) begin
      // Watchdog wins over everything, including same-cycle events.
      w_state_nxt = S_DONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_latch     = 1'b1;
            w_state_nxt = S_ADDR;
          end
        end
        S_HOLD: begin
          if (abort) begin
            w_state_nxt = S_STOP;
          end else if (start) begin
            w_latch     = 1'b1;
            w_rsc_set   = 1'b1;
            w_state_nxt = S_ADDR;
          end
        end
        S_ADDR: begin
          if (abort) begin
            w_state_nxt = S_STOP;
          end else if (addr_done) begin
            if (ack_n) begin
              w_nack_set  = 1'b1;
              w_state_nxt = S_STOP;
            end else if (r_rem == '0) begin
              w_state_nxt = S_STOP;           // address probe only
            end else if (!r_rw && tx_empty) begin
              w_state_nxt = S_STALL;
            end else begin
              w_state_nxt  = S_DATA;
              w_enter_data = 1'b1;
            end
          end
        end
        S_DATA: begin
          if (abort) begin
            w_state_nxt = S_STOP;
          end else if (byte_done) begin
            w_dec = 1'b1;
            if (!r_rw && ack_n) begin
              w_nack_set  = 1'b1;
              w_state_nxt = S_STOP;
            end else if (r_rw && rx_full) begin
              // Byte is counted now; the RX push is deferred to STALL.
              w_state_nxt = S_STALL;
            end else begin
              w_rx_pulse = r_rw;
              if (w_rem_dec != '0) begin
                if (!r_rw && tx_empty) begin
                  w_state_nxt = S_STALL;
                end else begin
                  w_state_nxt  = S_DATA;
                  w_enter_data = 1'b1;
                end
              end else begin
                w_state_nxt = (r_rep && !r_nack) ? S_HOLD : S_STOP;
              end
            end
          end
        end
        S_STALL: begin
          if (abort) begin
            w_state_nxt = S_STOP;
          end else if (r_rw) begin
            // Read stall: byte already counted, push it once the FIFO frees.
            if (!rx_full) begin
              w_rx_pulse = 1'b1;
              if (r_rem != '0) begin
                w_state_nxt  = S_DATA;
                w_enter_data = 1'b1;
              end else begin
                w_state_nxt = (r_rep && !r_nack) ? S_HOLD : S_STOP;
              end
            end
          end else if (!tx_empty) begin
            w_state_nxt  = S_DATA;
            w_enter_data = 1'b1;
          end
        end
        S_STOP: begin
          if (bus_idle) w_state_nxt = S_DONE;
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_rep     <= 1'b0;
      r_rem     <= '0;
      r_nack    <= 1'b0;
      r_rsc     <= 1'b0;
      r_tx_pend <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rsc     <= w_rsc_set;
      // TX pop is issued on the first cycle of every write DATA entry.
      r_tx_pend <= w_enter_data & ~r_rw;
      if (w_latch) begin
        r_rw   <= rw;
        r_addr <= slave_addr;
        r_rep  <= rep_start;
        r_rem  <= byte_count;
        r_nack <= 1'b0;
      end else begin
        if (w_dec)      r_rem  <= w_rem_dec;
        if (w_nack_set) r_nack <= 1'b1;
      end
    end
  end

`ifdef I2C_SEQ_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_tout;
  logic              w_wdog_state;

  assign w_wdog_state = (r_state == S_ADDR) || (r_state == S_DATA) ||
                        (r_state == S_STOP);
  assign w_wdog_fire  = w_wdog_state &&
                        (r_wdog == WDOG_W'(WDOG_CYCLES - 1));

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
      r_tout <= 1'b0;
    end else begin
      if (w_state_nxt != r_state) r_wdog <= '0;
      else if (w_wdog_state)      r_wdog <= r_wdog + 1'b1;
      if (w_latch)          r_tout <= 1'b0;
      else if (w_wdog_fire) r_tout <= 1'b1;
    end
  end

  assign timeout_err = r_tout;
`else
  // Never true; keeps WDOG_CYCLES referenced so both builds share one
  // parameter list.
  assign w_wdog_fire = (WDOG_CYCLES < 0);
  assign timeout_err = 1'b0;
`endif

  assign i2c_enable          = (r_state == S_ADDR) || (r_state == S_DATA) ||
                               (r_state == S_STALL) || (r_state == S_HOLD);
  assign i2c_rw              = r_rw;
  assign i2c_addr            = r_addr;
  assign repeated_start_cond = r_rsc;
  assign i2c_hold            = (r_state == S_STALL);
  assign fifo_tx_enable      = r_tx_pend & ~abort;
  assign fifo_rx_enable      = w_rx_pulse;
  assign busy                = (r_state != S_IDLE) && (r_state != S_HOLD);
  assign done                = (r_state == S_DONE);
  assign nack_err            = r_nack;
  assign remaining           = r_rem;

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
module tb_i2c_xfer_sequencer;
  localparam int CNT_W = 4;

  logic             core_clk = 1'b0;
  logic             rst_n;
  logic             start, abort, rw, rep_start;
  logic [6:0]       slave_addr;
  logic [CNT_W-1:0] byte_count;
  logic             addr_done, byte_done, ack_n, bus_idle, tx_empty, rx_full;
  logic             i2c_enable, i2c_rw, repeated_start_cond, i2c_hold;
  logic [6:0]       i2c_addr;
  logic             fifo_tx_enable, fifo_rx_enable, busy, done;
  logic             nack_err, timeout_err;
  logic [CNT_W-1:0] remaining;

  int n_vec = 0;
  int n_err = 0;
  int tx_tot = 0, rx_tot = 0, hold_tot = 0, done_tot = 0, rsc_tot = 0;

  i2c_xfer_sequencer #(.CNT_W(CNT_W), .WDOG_CYCLES(16)) dut (
    .core_clk(core_clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rw(rw), .slave_addr(slave_addr), .byte_count(byte_count),
    .rep_start(rep_start), .addr_done(addr_done), .byte_done(byte_done),
    .ack_n(ack_n), .bus_idle(bus_idle), .tx_empty(tx_empty),
    .rx_full(rx_full), .i2c_enable(i2c_enable), .i2c_rw(i2c_rw),
    .i2c_addr(i2c_addr), .repeated_start_cond(repeated_start_cond),
    .i2c_hold(i2c_hold), .fifo_tx_enable(fifo_tx_enable),
    .fifo_rx_enable(fifo_rx_enable), .busy(busy), .done(done),
    .nack_err(nack_err), .timeout_err(timeout_err), .remaining(remaining)
  );

  always #5 core_clk = ~core_clk;

  // Pulse/level counters sampled mid-cycle, away from the active edge.
  always @(negedge core_clk) begin
    if (rst_n) begin
      if (fifo_tx_enable)      tx_tot   <= tx_tot + 1;
      if (fifo_rx_enable)      rx_tot   <= rx_tot + 1;
      if (i2c_hold)            hold_tot <= hold_tot + 1;
      if (done)                done_tot <= done_tot + 1;
      if (repeated_start_cond) rsc_tot  <= rsc_tot + 1;
    end
  end

  task automatic tick;
    @(posedge core_clk); #1;
  endtask

  task automatic do_start(input logic r, input logic [6:0] a,
                          input logic [CNT_W-1:0] c, input logic rep);
    start = 1'b1; rw = r; slave_addr = a; byte_count = c; rep_start = rep;
    tick;
    start = 1'b0;
  endtask

  task automatic pulse_addr(input logic nak);
    addr_done = 1'b1; ack_n = nak;
    tick;
    addr_done = 1'b0; ack_n = 1'b0;
  endtask

  task automatic pulse_byte(input logic nak);
    byte_done = 1'b1; ack_n = nak;
    tick;
    byte_done = 1'b0; ack_n = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_vec++; if ({busy, i2c_enable, done, i2c_hold} !== 4'b0) begin n_err++; $display("FAIL reset_ctl: got %b want 0000", {busy, i2c_enable, done, i2c_hold}); end
    n_vec++; if ({nack_err, timeout_err, fifo_tx_enable, fifo_rx_enable, repeated_start_cond} !== 5'b0) begin n_err++; $display("FAIL reset_flags: got %b want 00000", {nack_err, timeout_err, fifo_tx_enable, fifo_rx_enable, repeated_start_cond}); end
    n_vec++; if (remaining !== 4'd0 || i2c_addr !== 7'd0) begin n_err++; $display("FAIL reset_regs: got rem=%0d addr=%0h want 0 0", remaining, i2c_addr); end
    @(negedge core_clk); rst_n = 1'b1;
    tick;
  endtask

  task automatic test_write;
    int t0, d0, n;
    t0 = tx_tot; d0 = done_tot;
    do_start(1'b0, 7'h50, 4'd3, 1'b0);
    n_vec++; if ({i2c_enable, busy, i2c_rw} !== 3'b110 || i2c_addr !== 7'h50) begin n_err++; $display("FAIL wr_addr_phase: got en/busy/rw=%b addr=%0h want 110 50", {i2c_enable, busy, i2c_rw}, i2c_addr); end
    n_vec++; if (remaining !== 4'd3) begin n_err++; $display("FAIL wr_latch_cnt: got %0d want 3", remaining); end
    pulse_addr(1'b0);
    tick;
    // start must be ignored mid-transfer
    start = 1'b1; slave_addr = 7'h7f; byte_count = 4'd9; tick; start = 1'b0;
    n_vec++; if (i2c_addr !== 7'h50 || remaining !== 4'd3) begin n_err++; $display("FAIL wr_start_ignored: got addr=%0h rem=%0d want 50 3", i2c_addr, remaining); end
    for (int i = 0; i < 3; i++) begin
      pulse_byte(1'b0);
      if (i < 2) tick;
    end
    n_vec++; if (i2c_enable !== 1'b0 || busy !== 1'b1 || remaining !== 4'd0) begin n_err++; $display("FAIL wr_stop: got en=%b busy=%b rem=%0d want 0 1 0", i2c_enable, busy, remaining); end
    n = 0; while (done !== 1'b1 && n < 10) begin tick; n++; end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL wr_done_wait: got %b want 1", done); end
    tick;
    n_vec++; if (tx_tot - t0 !== 3 || done_tot - d0 !== 1) begin n_err++; $display("FAIL wr_pulses: got tx=%0d done=%0d want 3 1", tx_tot - t0, done_tot - d0); end
    n_vec++; if (nack_err !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL wr_end: got nack=%b busy=%b want 0 0", nack_err, busy); end
  endtask

  task automatic test_read_stall;
    int r0, h0, d0, n;
    r0 = rx_tot; h0 = hold_tot; d0 = done_tot;
    do_start(1'b1, 7'h23, 4'd2, 1'b0);
    pulse_addr(1'b0);
    tick;
    pulse_byte(1'b0);
    n_vec++; if (rx_tot - r0 !== 1 || remaining !== 4'd1) begin n_err++; $display("FAIL rd_byte1: got rx=%0d rem=%0d want 1 1", rx_tot - r0, remaining); end
    tick;
    rx_full = 1'b1;
    pulse_byte(1'b0);
    repeat (4) tick;
    n_vec++; if (i2c_hold !== 1'b1 || rx_tot - r0 !== 1) begin n_err++; $display("FAIL rd_stalled: got hold=%b rx=%0d want 1 1", i2c_hold, rx_tot - r0); end
    rx_full = 1'b0;
    tick;
    n = 0; while (done !== 1'b1 && n < 10) begin tick; n++; end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL rd_done_wait: got %b want 1", done); end
    tick;
    n_vec++; if (hold_tot - h0 !== 5 || rx_tot - r0 !== 2) begin n_err++; $display("FAIL rd_stall_counts: got hold=%0d rx=%0d want 5 2", hold_tot - h0, rx_tot - r0); end
    n_vec++; if (remaining !== 4'd0 || done_tot - d0 !== 1) begin n_err++; $display("FAIL rd_end: got rem=%0d done=%0d want 0 1", remaining, done_tot - d0); end
  endtask

  task automatic test_addr_nack;
    int t0, d0, n;
    t0 = tx_tot; d0 = done_tot;
    bus_idle = 1'b0;
    do_start(1'b0, 7'h3c, 4'd2, 1'b0);
    pulse_addr(1'b1);
    n_vec++; if (nack_err !== 1'b1 || i2c_enable !== 1'b0) begin n_err++; $display("FAIL nak_flag: got nack=%b en=%b want 1 0", nack_err, i2c_enable); end
    repeat (3) tick;
    n_vec++; if (busy !== 1'b1 || done_tot !== d0) begin n_err++; $display("FAIL nak_stop_wait: got busy=%b done=%0d want 1 0", busy, done_tot - d0); end
    bus_idle = 1'b1;
    n = 0; while (done !== 1'b1 && n < 10) begin tick; n++; end
    tick;
    n_vec++; if (tx_tot - t0 !== 0 || done_tot - d0 !== 1 || nack_err !== 1'b1) begin n_err++; $display("FAIL nak_end: got tx=%0d done=%0d nack=%b want 0 1 1", tx_tot - t0, done_tot - d0, nack_err); end
  endtask

  task automatic test_rep_start;
    int t0, r0, d0, s0, n;
    t0 = tx_tot; r0 = rx_tot; d0 = done_tot; s0 = rsc_tot;
    do_start(1'b0, 7'h11, 4'd1, 1'b1);
    n_vec++; if (nack_err !== 1'b0) begin n_err++; $display("FAIL rs_nack_clr: got %b want 0", nack_err); end
    pulse_addr(1'b0);
    pulse_byte(1'b0);
    repeat (3) tick;
    n_vec++; if (busy !== 1'b0 || i2c_enable !== 1'b1 || done_tot !== d0) begin n_err++; $display("FAIL rs_hold: got busy=%b en=%b done=%0d want 0 1 0", busy, i2c_enable, done_tot - d0); end
    do_start(1'b1, 7'h12, 4'd1, 1'b0);
    n_vec++; if (repeated_start_cond !== 1'b1 || i2c_rw !== 1'b1 || i2c_addr !== 7'h12) begin n_err++; $display("FAIL rs_cond: got rsc=%b rw=%b addr=%0h want 1 1 12", repeated_start_cond, i2c_rw, i2c_addr); end
    tick;
    n_vec++; if (repeated_start_cond !== 1'b0) begin n_err++; $display("FAIL rs_cond_width: got %b want 0", repeated_start_cond); end
    pulse_addr(1'b0);
    pulse_byte(1'b0);
    n_vec++; if (i2c_enable !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL rs_stop: got en=%b busy=%b want 0 1", i2c_enable, busy); end
    n = 0; while (done !== 1'b1 && n < 10) begin tick; n++; end
    tick;
    n_vec++; if (rsc_tot - s0 !== 1 || tx_tot - t0 !== 1 || rx_tot - r0 !== 1 || done_tot - d0 !== 1) begin n_err++; $display("FAIL rs_counts: got rsc=%0d tx=%0d rx=%0d done=%0d want 1 1 1 1", rsc_tot - s0, tx_tot - t0, rx_tot - r0, done_tot - d0); end
  endtask

  task automatic test_abort;
    int t0, r0, n;
    t0 = tx_tot; r0 = rx_tot;
    do_start(1'b0, 7'h33, 4'd3, 1'b0);
    pulse_addr(1'b0);
    tick;
    pulse_byte(1'b0);
    tick;
    abort = 1'b1; byte_done = 1'b1;
    tick;
    abort = 1'b0; byte_done = 1'b0;
    n_vec++; if (i2c_enable !== 1'b0 || busy !== 1'b1 || remaining !== 4'd2) begin n_err++; $display("FAIL ab_stop: got en=%b busy=%b rem=%0d want 0 1 2", i2c_enable, busy, remaining); end
    n_vec++; if (tx_tot - t0 !== 2 || rx_tot - r0 !== 0) begin n_err++; $display("FAIL ab_fifo: got tx=%0d rx=%0d want 2 0", tx_tot - t0, rx_tot - r0); end
    n = 0; while (done !== 1'b1 && n < 10) begin tick; n++; end
    tick;
    // abort and stray controller events in IDLE do nothing
    abort = 1'b1; addr_done = 1'b1; byte_done = 1'b1;
    tick; tick;
    abort = 1'b0; addr_done = 1'b0; byte_done = 1'b0;
    n_vec++; if (busy !== 1'b0 || i2c_enable !== 1'b0 || remaining !== 4'd2) begin n_err++; $display("FAIL ab_idle: got busy=%b en=%b rem=%0d want 0 0 2", busy, i2c_enable, remaining); end
  endtask

  task automatic test_stall_probe;
    int t0, n;
    t0 = tx_tot;
    tx_empty = 1'b1;
    do_start(1'b0, 7'h44, 4'd1, 1'b0);
    pulse_addr(1'b0);
    tick; tick;
    n_vec++; if (i2c_hold !== 1'b1 || i2c_enable !== 1'b1 || tx_tot !== t0) begin n_err++; $display("FAIL tx_stall: got hold=%b en=%b tx=%0d want 1 1 0", i2c_hold, i2c_enable, tx_tot - t0); end
    tx_empty = 1'b0;
    tick;
    n_vec++; if (i2c_hold !== 1'b0 || fifo_tx_enable !== 1'b1) begin n_err++; $display("FAIL tx_resume: got hold=%b txen=%b want 0 1", i2c_hold, fifo_tx_enable); end
    pulse_byte(1'b0);
    n = 0; while (done !== 1'b1 && n < 10) begin tick; n++; end
    tick;
    n_vec++; if (tx_tot - t0 !== 1) begin n_err++; $display("FAIL tx_stall_cnt: got %0d want 1", tx_tot - t0); end
    // zero-length transfer: address probe only
    t0 = tx_tot;
    do_start(1'b0, 7'h45, 4'd0, 1'b0);
    pulse_addr(1'b0);
    n_vec++; if (i2c_enable !== 1'b0 || busy !== 1'b1 || nack_err !== 1'b0) begin n_err++; $display("FAIL probe_stop: got en=%b busy=%b nack=%b want 0 1 0", i2c_enable, busy, nack_err); end
    n = 0; while (done !== 1'b1 && n < 10) begin tick; n++; end
    tick;
    n_vec++; if (tx_tot !== t0) begin n_err++; $display("FAIL probe_tx: got %0d want 0", tx_tot - t0); end
  endtask

  task automatic test_wdog;
    int n;
    do_start(1'b0, 7'h66, 4'd1, 1'b0);
`ifdef I2C_SEQ_WDOG_EN
    n = 0; while (done !== 1'b1 && n < 40) begin tick; n++; end
    n_vec++; if (n !== 16 || done !== 1'b1) begin n_err++; $display("FAIL wd_latency: got %0d cycles done=%b want 16 1", n, done); end
    n_vec++; if (timeout_err !== 1'b1 || i2c_enable !== 1'b0) begin n_err++; $display("FAIL wd_flags: got tout=%b en=%b want 1 0", timeout_err, i2c_enable); end
    tick;
`else
    repeat (40) tick;
    n_vec++; if (timeout_err !== 1'b0 || busy !== 1'b1 || i2c_enable !== 1'b1) begin n_err++; $display("FAIL nowd_wait: got tout=%b busy=%b en=%b want 0 1 1", timeout_err, busy, i2c_enable); end
    abort = 1'b1; tick; abort = 1'b0;
    n = 0; while (done !== 1'b1 && n < 10) begin tick; n++; end
    tick;
`endif
  endtask

  task automatic test_reset_mid;
    do_start(1'b1, 7'h22, 4'd2, 1'b0);
    pulse_addr(1'b0);
    n_vec++; if (i2c_enable !== 1'b1) begin n_err++; $display("FAIL rm_pre: got en=%b want 1", i2c_enable); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (i2c_enable !== 1'b0 || busy !== 1'b0 || remaining !== 4'd0) begin n_err++; $display("FAIL rm_drop: got en=%b busy=%b rem=%0d want 0 0 0", i2c_enable, busy, remaining); end
    @(negedge core_clk); rst_n = 1'b1;
    tick;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rw = 1'b0; rep_start = 1'b0;
    slave_addr = '0; byte_count = '0; addr_done = 1'b0; byte_done = 1'b0;
    ack_n = 1'b0; bus_idle = 1'b1; tx_empty = 1'b0; rx_full = 1'b0;
    test_reset;
    test_write;
    test_read_stall;
    test_addr_nack;
    test_rep_start;
    test_abort;
    test_stall_probe;
    test_wdog;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_xfer_sequencer.md
I2C_XFER_SEQUENCER -- requirements
Module: i2c_xfer_sequencer

Interface
REQ-001 Parameter: CNT_W, 4, width of byte_count; maximum transfer of 2^CNT_W-1 bytes.
REQ-002 Parameter: WDOG_CYCLES, 1024, number of core_clk cycles the watchdog waits for a controller event (used only with I2C_SEQ_WDOG_EN).
REQ-003 Port: core_clk  in  1  block clock; all logic is rising-edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Ports: start in 1, pulse that requests a transfer; abort in 1, level that forces termination; rw in 1, 1=read and 0=write; slave_addr in 7, target address; byte_count in CNT_W, number of data bytes; rep_start in 1, end the transfer without STOP.
REQ-006 Controller-side inputs: addr_done in 1, pulse when the address byte and ACK slot have completed; byte_done in 1, pulse when a data byte and ACK slot have completed; ack_n in 1, ACK bit sampled with addr_done or byte_done; bus_idle in 1, STOP has completed and the bus is free.
REQ-007 FIFO-side inputs: tx_empty in 1; rx_full in 1.
REQ-008 Outputs: i2c_enable out 1; i2c_rw out 1; i2c_addr out 7; repeated_start_cond out 1; i2c_hold out 1, clock-stretch request; fifo_tx_enable out 1; fifo_rx_enable out 1.
REQ-009 Status outputs: busy out 1; done out 1, single-cycle pulse; nack_err out 1, sticky; timeout_err out 1, sticky; remaining out CNT_W.

Function
REQ-010 States: IDLE, ADDR, DATA, STALL, STOP, HOLD, DONE.
REQ-011 IDLE: busy=0, i2c_enable=0; on start, latch rw, slave_addr, byte_count and rep_start, clear nack_err and timeout_err, and go to ADDR on the next cycle.
REQ-012 HOLD (bus retained after rep_start): i2c_enable=1; on start, latch the new fields, pulse repeated_start_cond for 1 cycle, and go to ADDR.
REQ-013 start is ignored in ADDR, DATA, STALL, STOP and DONE.
REQ-014 ADDR: i2c_enable=1, with i2c_rw and i2c_addr driven from the latched values; wait for addr_done.
REQ-015 ADDR exits on addr_done: ack_n=1 sets nack_err and goes to STOP; count=0 goes to STOP (address probe).
REQ-016 ADDR exit for a write with count>0: go to STALL if tx_empty=1, else go to DATA.
REQ-017 ADDR exit for a read with count>0: go to DATA.
REQ-018 Write path: fifo_tx_enable pulses for exactly 1 cycle on each entry to DATA; then wait for byte_done.
REQ-019 Read path: on byte_done, fifo_rx_enable pulses in the same cycle if rx_full=0; if rx_full=1, go to STALL and pulse fifo_rx_enable on the first cycle rx_full=0.
REQ-020 remaining decrements by 1 per completed byte and never wraps below 0.
REQ-021 On a write byte_done with ack_n=1: set nack_err and go to STOP regardless of remaining.
REQ-022 After a byte completes with remaining>0: go to DATA, or STALL if write and tx_empty=1.
REQ-023 After the last byte: go to HOLD if rep_start=1 and no error, else go to STOP.
REQ-024 STALL: i2c_hold=1 and i2c_enable=1; exit when the blocking FIFO condition clears.
REQ-025 STOP: i2c_enable=0; wait for bus_idle=1, then go to DONE.
REQ-026 DONE: done=1 for 1 cycle, then go to IDLE.
REQ-027 busy=1 in every state except IDLE and HOLD.
REQ-028 abort=1 in any state other than IDLE, STOP or DONE forces STOP on the next cycle.
REQ-029 abort has priority over simultaneous addr_done or byte_done; a FIFO pulse does not occur on the abort cycle.
REQ-030 An addr_done or byte_done received outside its expected state is ignored.

Reset
REQ-031 When rst_n=0, state=IDLE and all outputs=0, including remaining, nack_err and timeout_err.
REQ-032 Reset mid-transfer drops i2c_enable immediately, without waiting for bus_idle.

Configuration
REQ-033 With macro I2C_SEQ_WDOG_EN defined, a counter clears on every state change and counts cycles spent in ADDR, DATA or STOP.
REQ-034 Watchdog action: at WDOG_CYCLES the block sets timeout_err, forces i2c_enable=0 and goes to DONE.
REQ-035 Without I2C_SEQ_WDOG_EN, no counter exists, timeout_err is tied to 0, and waits are unbounded.

Verification
REQ-036 Write, addr 0x50, count 3, tx_empty=0, all ACK -> 3 fifo_tx_enable pulses, STOP, done pulse, nack_err=0, remaining=0.
REQ-037 Read, count 2, rx_full=1 at the 2nd byte_done for 5 cycles -> i2c_hold=1 for 5 cycles, then 1 fifo_rx_enable pulse, STOP, done.
REQ-038 Write, ack_n=1 at addr_done -> nack_err=1, no fifo_tx_enable, STOP, done.
REQ-039 Write count 1 with rep_start=1, then read count 1 -> HOLD with i2c_enable=1, repeated_start_cond for 1 cycle, then read completes with STOP.
REQ-040 abort coincident with byte_done in DATA -> STOP next cycle, no FIFO pulse, remaining unchanged.
REQ-041 With I2C_SEQ_WDOG_EN and WDOG_CYCLES=16, no addr_done for 16 cycles -> timeout_err=1, i2c_enable=0, done pulse.
